// File: rtl/cc_speed_pkg.sv
// cc_speed_pkg: shared defaults and select clamp for the speed selector
package cc_speed_pkg;
  localparam int CC_SPEED_NUM_DEFAULT = 4;
  localparam int CC_SPEED_CNT_W = 24;
  localparam logic [CC_SPEED_NUM_DEFAULT-1:0][CC_SPEED_CNT_W-1:0] CC_SPEED_DEFAULT_PERIODS = {
    24'd312_500, 24'd625_000, 24'd1_250_000, 24'd2_500_000
  };
  function automatic int cc_speed_clamp(input int sel, input int num);
    return (sel >= num) ? num - 1 : sel;
  endfunction
endpackage

// File: rtl/cc_speed_counter.sv
// cc_speed_counter: loadable down-counter that parks at zero
module cc_speed_counter #(
  parameter int CNT_W = 24,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             hold,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);
  logic [CNT_W-1:0] cnt;
  assign zero = (cnt == '0);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= RST_VAL;
    else if (load) cnt <= load_val;
    else if (!hold && !zero) cnt <= cnt - CNT_W'(1);
endmodule

// File: rtl/cc_speed_select.sv
// cc_speed_select: N-way speed table with tick generation; speed changes apply only at tick boundaries
module cc_speed_select
  import cc_speed_pkg::*;
#(
  parameter int NUM_SPEEDS = CC_SPEED_NUM_DEFAULT,
  parameter int SEL_W = $clog2(NUM_SPEEDS),
  parameter int CNT_W = CC_SPEED_CNT_W,
  parameter logic [NUM_SPEEDS-1:0][CNT_W-1:0] SPEED_PERIODS = CC_SPEED_DEFAULT_PERIODS
) (
  input  logic             CC_SPEEDSELECT_CLOCK_50,
  input  logic             CC_SPEEDSELECT_RESET_InLow,
  input  logic [SEL_W-1:0] CC_SPEEDSELECT_select_In,
  input  logic             CC_SPEEDSELECT_pause_InHigh,
  input  logic             CC_SPEEDSELECT_restart_InHigh,
  output logic             CC_SPEEDSELECT_tick_Out,
  output logic [SEL_W-1:0] CC_SPEEDSELECT_speed_Out,
  output logic             CC_SPEEDSELECT_pending_Out
);
  logic [SEL_W-1:0] sel_pend, sel_act, sel_clamp;
  logic [CNT_W-1:0] reload;
  logic tick, zero, load;
  assign sel_clamp = SEL_W'(cc_speed_clamp(int'(CC_SPEEDSELECT_select_In), NUM_SPEEDS));
  assign reload = SPEED_PERIODS[sel_pend] - CNT_W'(1);
  // restart overrides pause; a natural reload only happens while running
  assign load = CC_SPEEDSELECT_restart_InHigh | (~CC_SPEEDSELECT_pause_InHigh & zero);
  cc_speed_counter #(
    .CNT_W(CNT_W),
    .RST_VAL(SPEED_PERIODS[0] - CNT_W'(1))
  ) u_cnt (
    .clk(CC_SPEEDSELECT_CLOCK_50),
    .rst_n(CC_SPEEDSELECT_RESET_InLow),
    .load(load),
    .hold(CC_SPEEDSELECT_pause_InHigh),
    .load_val(reload),
    .zero(zero)
  );
  always_ff @(posedge CC_SPEEDSELECT_CLOCK_50 or negedge CC_SPEEDSELECT_RESET_InLow)
    if (!CC_SPEEDSELECT_RESET_InLow) begin
      sel_pend <= '0;
      sel_act  <= '0;
      tick     <= 1'b0;
    end else begin
      sel_pend <= sel_clamp;
      sel_act  <= load ? sel_pend : sel_act;
      tick     <= ~CC_SPEEDSELECT_restart_InHigh & ~CC_SPEEDSELECT_pause_InHigh & zero;
    end
  assign CC_SPEEDSELECT_tick_Out = tick;
  assign CC_SPEEDSELECT_speed_Out = sel_act;
  assign CC_SPEEDSELECT_pending_Out = (sel_pend != sel_act);
endmodule

// File: tb/tb_cc_speed_select.sv
// tb_cc_speed_select: randomized bench against a tick-schedule reference model, two configurations
module tb_cc_speed_select;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [1:0] sel = '0, sel3 = '0;
  logic pause = 1'b0, restart = 1'b0;
  logic tick0, tick1, pnd0, pnd1;
  logic [1:0] spd0, spd1;
  int checks = 0, failures = 0, cyc = 0;
  int per[2][4] = '{'{4, 6, 10, 20}, '{4, 6, 10, 0}};
  int nsp[2] = '{4, 3};
  int next_t[2], pend[2], act[2];

  always #5 clk = ~clk;

  cc_speed_select #(
    .NUM_SPEEDS(4), .CNT_W(24),
    .SPEED_PERIODS({24'd20, 24'd10, 24'd6, 24'd4})
  ) u_dut (
    .CC_SPEEDSELECT_CLOCK_50(clk),
    .CC_SPEEDSELECT_RESET_InLow(rst_n),
    .CC_SPEEDSELECT_select_In(sel),
    .CC_SPEEDSELECT_pause_InHigh(pause),
    .CC_SPEEDSELECT_restart_InHigh(restart),
    .CC_SPEEDSELECT_tick_Out(tick0),
    .CC_SPEEDSELECT_speed_Out(spd0),
    .CC_SPEEDSELECT_pending_Out(pnd0)
  );

  cc_speed_select #(
    .NUM_SPEEDS(3), .CNT_W(24),
    .SPEED_PERIODS({24'd10, 24'd6, 24'd4})
  ) u_dut3 (
    .CC_SPEEDSELECT_CLOCK_50(clk),
    .CC_SPEEDSELECT_RESET_InLow(rst_n),
    .CC_SPEEDSELECT_select_In(sel3),
    .CC_SPEEDSELECT_pause_InHigh(pause),
    .CC_SPEEDSELECT_restart_InHigh(restart),
    .CC_SPEEDSELECT_tick_Out(tick1),
    .CC_SPEEDSELECT_speed_Out(spd1),
    .CC_SPEEDSELECT_pending_Out(pnd1)
  );

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic check_outs(input int et0, input int es0, input int ep0,
                            input int et1, input int es1, input int ep1);
    check("tick", int'(tick0), et0);
    check("speed", int'(spd0), es0);
    check("pending", int'(pnd0), ep0);
    check("tick3", int'(tick1), et1);
    check("speed3", int'(spd1), es1);
    check("pending3", int'(pnd1), ep1);
  endtask

  // asserts reset between edges, checks outputs clear without a clock, releases after n edges
  task automatic do_reset(input int n);
    #2 rst_n = 1'b0;
    #1 check_outs(0, 0, 0, 0, 0, 0);
    repeat (n) begin
      @(posedge clk);
      #1 check_outs(0, 0, 0, 0, 0, 0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    for (int m = 0; m < 2; m++) begin
      next_t[m] = per[m][0];
      pend[m] = 0;
      act[m] = 0;
    end
  endtask

  // next tick is scheduled as an absolute cycle number; pause pushes it out, restart reschedules it
  task automatic step(input int s, input int s3, input logic p, input logic r);
    int et[2];
    int sv[2];
    sel = 2'(s);
    sel3 = 2'(s3);
    pause = p;
    restart = r;
    sv[0] = s;
    sv[1] = s3;
    @(posedge clk);
    cyc++;
    for (int m = 0; m < 2; m++) begin
      et[m] = 0;
      if (r) begin
        next_t[m] = cyc + per[m][pend[m]];
        act[m] = pend[m];
      end else if (p) next_t[m]++;
      else if (cyc == next_t[m]) begin
        et[m] = 1;
        act[m] = pend[m];
        next_t[m] = cyc + per[m][pend[m]];
      end
      pend[m] = (sv[m] >= nsp[m]) ? nsp[m] - 1 : sv[m];
    end
    #1 check_outs(et[0], act[0], int'(pend[0] != act[0]), et[1], act[1], int'(pend[1] != act[1]));
  endtask

  initial begin
    @(negedge clk);
    do_reset(3);
    for (int c = 1; c <= 13; c++) step(0, 0, 0, 0);
    do_reset(1);
    for (int c = 1; c <= 30; c++) step(c >= 5 ? 2 : 0, 3, 0, 0);
    check("clamp3", int'(spd1), 2);
    do_reset(1);
    for (int c = 1; c <= 15; c++) step(c == 4 ? 1 : 0, 0, c >= 2 && c <= 6, 0);
    do_reset(1);
    for (int c = 1; c <= 20; c++) step(0, 0, c == 12, c == 8 || c == 12);
    do_reset(1);
    for (int c = 1; c <= 25; c++) step(3, 2, 0, 0);
    do_reset(2);
    for (int c = 1; c <= 12; c++) step(0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset($urandom_range(0, 2));
      step($urandom_range(0, 9) < 8 ? int'(sel) : $urandom_range(0, 3),
           $urandom_range(0, 9) < 8 ? int'(sel3) : $urandom_range(0, 3),
           $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
